// File: rtl/axi_lite_gpio_pkg.sv
// Shared definitions for the GPIO pin-side stage: register word indices
// and the byte-lane merge used by every writable register.
package axi_lite_gpio_pkg;

  localparam int REG_W = 32;

  localparam logic [1:0] ADDR_OUT = 2'd0;
  localparam logic [1:0] ADDR_DIR = 2'd1;
  localparam logic [1:0] ADDR_IN  = 2'd2;
  localparam logic [1:0] ADDR_IRQ = 2'd3;

  // Replace only the byte lanes whose strobe is set; other lanes keep old_val.
  function automatic logic [REG_W-1:0] merge_strb(
    input logic [REG_W-1:0] old_val,
    input logic [REG_W-1:0] new_val,
    input logic [3:0]       strb
  );
    logic [REG_W-1:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_gpio_in_filter.sv
// Pad input conditioning: 2-flop synchroniser, tick-paced debounce and
// registered rising-edge pulses, gated until the first post-reset sample.
module axi_lite_gpio_in_filter
  import axi_lite_gpio_pkg::*;
#(
  parameter int GPIO_WIDTH = 32,
  parameter int DEB_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] stable,
  output logic [GPIO_WIDTH-1:0] rise
);

  localparam int                CNT_W   = $clog2(DEB_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEB_DIV - 1);

  logic [GPIO_WIDTH-1:0] sync1;
  logic [GPIO_WIDTH-1:0] sync2;
  logic [GPIO_WIDTH-1:0] s0;
  logic [GPIO_WIDTH-1:0] stable_next;
  logic [CNT_W-1:0]      cnt;
  logic                  tick;
  logic                  armed;

  assign tick = (cnt == CNT_MAX);

  // A bit only moves when two consecutive tick samples agree.
  always_comb begin
    stable_next = (~(sync2 ^ s0) & sync2) | ((sync2 ^ s0) & stable);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= gpio_i;
      sync2 <= sync1;
      cnt   <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

  // The arming tick seeds s0/stable straight from the pad so a pin held
  // high through reset is not mistaken for a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0     <= '0;
      stable <= '0;
      armed  <= 1'b0;
      rise   <= '0;
    end else begin
      rise <= '0;
      if (tick) begin
        s0 <= sync2;
        if (!armed) begin
          stable <= sync2;
          armed  <= 1'b1;
        end else begin
          stable <= stable_next;
          rise   <= stable_next & ~stable;
        end
      end
    end
  end

endmodule

// File: rtl/axi_lite_gpio_pin_ctrl.sv
// GPIO pin-side register file: OUT/DIR/IN/IRQ_STAT behind the AXI-Lite
// slave's decoded strobes, driving pads and a level interrupt.
module axi_lite_gpio_pin_ctrl
  import axi_lite_gpio_pkg::*;
#(
  parameter int GPIO_WIDTH = 32,
  parameter int DEB_DIV    = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  reg_wr_en,
  input  logic [1:0]            reg_wr_addr,
  input  logic [31:0]           reg_wr_data,
  input  logic [3:0]            reg_wr_strb,
  input  logic                  reg_rd_en,
  input  logic [1:0]            reg_rd_addr,
  output logic [31:0]           reg_rd_data,
  output logic                  reg_rd_valid,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_t,
  output logic                  irq
);

  logic [GPIO_WIDTH-1:0] out_reg;
  logic [GPIO_WIDTH-1:0] dir_reg;
  logic [GPIO_WIDTH-1:0] irq_stat;
  logic [GPIO_WIDTH-1:0] in_val;
  logic [GPIO_WIDTH-1:0] rise;
  logic [GPIO_WIDTH-1:0] clr_mask;

  logic [REG_W-1:0] out_ext;
  logic [REG_W-1:0] dir_ext;
  logic [REG_W-1:0] in_ext;
  logic [REG_W-1:0] irq_ext;
  logic [REG_W-1:0] out_merged;
  logic [REG_W-1:0] dir_merged;
  logic [REG_W-1:0] clr_merged;
  logic [REG_W-1:0] rd_mux;

  logic wr_out;
  logic wr_dir;
  logic wr_irq;

  axi_lite_gpio_in_filter #(
    .GPIO_WIDTH (GPIO_WIDTH),
    .DEB_DIV    (DEB_DIV)
  ) u_filter (
    .clk    (ACLK),
    .reset  (ARESET),
    .gpio_i (gpio_i),
    .stable (in_val),
    .rise   (rise)
  );

  // Registers are zero-extended to the bus width so unused bits read as 0.
  always_comb begin
    out_ext = '0;
    dir_ext = '0;
    in_ext  = '0;
    irq_ext = '0;
    out_ext[GPIO_WIDTH-1:0] = out_reg;
    dir_ext[GPIO_WIDTH-1:0] = dir_reg;
    in_ext[GPIO_WIDTH-1:0]  = in_val;
    irq_ext[GPIO_WIDTH-1:0] = irq_stat;
  end

  always_comb begin
    wr_out     = reg_wr_en && (reg_wr_addr == ADDR_OUT);
    wr_dir     = reg_wr_en && (reg_wr_addr == ADDR_DIR);
    wr_irq     = reg_wr_en && (reg_wr_addr == ADDR_IRQ);
    out_merged = merge_strb(out_ext, reg_wr_data, reg_wr_strb);
    dir_merged = merge_strb(dir_ext, reg_wr_data, reg_wr_strb);
    clr_merged = merge_strb('0, reg_wr_data, reg_wr_strb);
    clr_mask   = wr_irq ? clr_merged[GPIO_WIDTH-1:0] : '0;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      out_reg <= '0;
      dir_reg <= '0;
    end else begin
      if (wr_out) out_reg <= out_merged[GPIO_WIDTH-1:0];
      if (wr_dir) dir_reg <= dir_merged[GPIO_WIDTH-1:0];
    end
  end

  // A new rise is ORed in after the clear, so a same-cycle set wins.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      irq_stat <= '0;
    end else begin
      irq_stat <= (irq_stat & ~clr_mask) | rise;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_rd_addr)
      ADDR_OUT: rd_mux = out_ext;
      ADDR_DIR: rd_mux = dir_ext;
      ADDR_IN:  rd_mux = in_ext;
      ADDR_IRQ: rd_mux = irq_ext;
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      reg_rd_data  <= '0;
      reg_rd_valid <= 1'b0;
    end else begin
      reg_rd_valid <= reg_rd_en;
      reg_rd_data  <= reg_rd_en ? rd_mux : '0;
    end
  end

  assign gpio_o = out_reg;
  assign gpio_t = ~dir_reg;
  assign irq    = |irq_stat;

endmodule

// File: tb/tb_axi_lite_gpio_pin_ctrl.sv
// Directed self-checking bench for axi_lite_gpio_pin_ctrl (32 pins, DEB_DIV = 4).
module tb_axi_lite_gpio_pin_ctrl;

  localparam int GPIO_WIDTH = 32;
  localparam int DEB_DIV    = 4;

  logic                  ACLK = 1'b0;
  logic                  ARESET;
  logic                  reg_wr_en;
  logic [1:0]            reg_wr_addr;
  logic [31:0]           reg_wr_data;
  logic [3:0]            reg_wr_strb;
  logic                  reg_rd_en;
  logic [1:0]            reg_rd_addr;
  logic [31:0]           reg_rd_data;
  logic                  reg_rd_valid;
  logic [GPIO_WIDTH-1:0] gpio_i;
  logic [GPIO_WIDTH-1:0] gpio_o;
  logic [GPIO_WIDTH-1:0] gpio_t;
  logic                  irq;

  int testsRun    = 0;
  int testsFailed = 0;

  axi_lite_gpio_pin_ctrl #(
    .GPIO_WIDTH (GPIO_WIDTH),
    .DEB_DIV    (DEB_DIV)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .reg_wr_en    (reg_wr_en),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .reg_wr_strb  (reg_wr_strb),
    .reg_rd_en    (reg_rd_en),
    .reg_rd_addr  (reg_rd_addr),
    .reg_rd_data  (reg_rd_data),
    .reg_rd_valid (reg_rd_valid),
    .gpio_i       (gpio_i),
    .gpio_o       (gpio_o),
    .gpio_t       (gpio_t),
    .irq          (irq)
  );

  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pads);
    gpio_i = pads;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge ACLK);
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [31:0] data, input logic [3:0] strb);
    reg_wr_en   = 1'b1;
    reg_wr_addr = addr;
    reg_wr_data = data;
    reg_wr_strb = strb;
    @(negedge ACLK);
    reg_wr_en   = 1'b0;
  endtask

  task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
    reg_rd_en   = 1'b1;
    reg_rd_addr = addr;
    @(negedge ACLK);
    reg_rd_en   = 1'b0;
    checkOutput("rd_valid", {31'b0, reg_rd_valid}, 32'h1);
    data = reg_rd_data;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_gpio_o"}, gpio_o, 32'h0);
    checkOutput({tag, "_gpio_t"}, gpio_t, 32'hFFFF_FFFF);
    checkOutput({tag, "_irq"}, {31'b0, irq}, 32'h0);
    checkOutput({tag, "_rd_valid"}, {31'b0, reg_rd_valid}, 32'h0);
    checkOutput({tag, "_rd_data"}, reg_rd_data, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    int          n;
    bit          seen;

    ARESET    = 1'b1;
    reg_wr_en = 1'b0;  reg_wr_addr = '0; reg_wr_data = '0; reg_wr_strb = '0;
    reg_rd_en = 1'b0;  reg_rd_addr = '0;
    applyStimulus(32'h0);
    waitCycles(3);
    ARESET = 1'b0;
    checkResetOutputs("reset");

    // Full writes to OUT and DIR, then read-back
    busWrite(2'd0, 32'h0000_00A5, 4'hF);
    checkOutput("gpio_o_a5", gpio_o, 32'h0000_00A5);
    busWrite(2'd1, 32'h0000_00FF, 4'hF);
    checkOutput("gpio_t_dir", gpio_t, 32'hFFFF_FF00);
    busRead(2'd0, rd);
    checkOutput("rd_out", rd, 32'h0000_00A5);
    busRead(2'd1, rd);
    checkOutput("rd_dir", rd, 32'h0000_00FF);
    @(negedge ACLK);
    checkOutput("rd_valid_drop", {31'b0, reg_rd_valid}, 32'h0);

    // Byte-lane write and read-only IN
    busWrite(2'd0, 32'h0, 4'hF);
    busWrite(2'd0, 32'hFFFF_FFFF, 4'h2);
    checkOutput("gpio_o_lane1", gpio_o, 32'h0000_FF00);
    busRead(2'd0, rd);
    checkOutput("rd_out_lane1", rd, 32'h0000_FF00);
    busWrite(2'd2, 32'hFFFF_FFFF, 4'hF);
    busRead(2'd2, rd);
    checkOutput("in_ro", rd, 32'h0);

    // Simultaneous write and read of OUT returns the old value
    reg_wr_en = 1'b1; reg_wr_addr = 2'd0; reg_wr_data = 32'h0000_0011; reg_wr_strb = 4'hF;
    reg_rd_en = 1'b1; reg_rd_addr = 2'd0;
    @(negedge ACLK);
    reg_wr_en = 1'b0; reg_rd_en = 1'b0;
    checkOutput("rw_same_old", reg_rd_data, 32'h0000_FF00);
    checkOutput("rw_same_new", gpio_o, 32'h0000_0011);

    // Rising edge on pin 3: irq at edges 8..11 after the change
    applyStimulus(32'h0000_0008);
    n = 0;
    while (n < 40 && !irq) begin
      @(negedge ACLK);
      n++;
    end
    checkOutput("irq_rise3", {31'b0, irq}, 32'h1);
    checkOutput("irq_latency", {31'b0, 1'(n >= 8 && n <= 11)}, 32'h1);
    busRead(2'd2, rd);
    checkOutput("in_bit3", rd, 32'h0000_0008);
    busRead(2'd3, rd);
    checkOutput("irq_stat3", rd, 32'h0000_0008);

    // 3-cycle glitch on pin 5 is rejected
    applyStimulus(32'h0000_0028);
    waitCycles(3);
    applyStimulus(32'h0000_0008);
    waitCycles(20);
    busRead(2'd2, rd);
    checkOutput("glitch_in", rd, 32'h0000_0008);
    busRead(2'd3, rd);
    checkOutput("glitch_irq", rd, 32'h0000_0008);

    // W1C clears the flag and drops irq
    busWrite(2'd3, 32'h0000_0008, 4'hF);
    checkOutput("w1c_irq", {31'b0, irq}, 32'h0);
    busRead(2'd3, rd);
    checkOutput("w1c_stat", rd, 32'h0);

    // Falling edge never flags
    applyStimulus(32'h0);
    waitCycles(20);
    checkOutput("fall_irq", {31'b0, irq}, 32'h0);
    busRead(2'd2, rd);
    checkOutput("fall_in", rd, 32'h0);

    // W1C landing in the same cycle as a new rise: set wins
    applyStimulus(32'h0000_0008);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (dut.u_filter.rise[3]) seen = 1'b1;
      else @(negedge ACLK);
    end
    checkOutput("rise_seen", {31'b0, seen}, 32'h1);
    busWrite(2'd3, 32'h0000_0008, 4'hF);
    checkOutput("set_wins_irq", {31'b0, irq}, 32'h1);
    busRead(2'd3, rd);
    checkOutput("set_wins_stat", rd, 32'h0000_0008);

    // All pins held high across reset: no spurious interrupt
    applyStimulus(32'hFFFF_FFFF);
    ARESET = 1'b1;
    waitCycles(3);
    ARESET = 1'b0;
    checkResetOutputs("hold_reset");
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      if (irq) seen = 1'b1;
    end
    checkOutput("hold_no_irq", {31'b0, seen}, 32'h0);
    busRead(2'd2, rd);
    checkOutput("hold_in", rd, 32'hFFFF_FFFF);
    busRead(2'd3, rd);
    checkOutput("hold_stat", rd, 32'h0);

    // Reset mid-debounce discards the pending edge
    busWrite(2'd0, 32'h0000_0012, 4'hF);
    busWrite(2'd1, 32'h0000_0034, 4'hF);
    applyStimulus(32'h0);
    waitCycles(20);
    busWrite(2'd3, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(32'h0000_0001);
    waitCycles(3);
    ARESET = 1'b1;
    @(negedge ACLK);
    checkResetOutputs("mid_reset");
    ARESET = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (irq) seen = 1'b1;
    end
    checkOutput("mid_no_irq", {31'b0, seen}, 32'h0);
    busRead(2'd2, rd);
    checkOutput("mid_in", rd, 32'h0000_0001);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
